qupls_mc_sequencer: RTL



---
 rtl/qupls_mc_sequencer.sv | 87 ++++++++
 1 files changed

// File: rtl/qupls_mc_sequencer.sv
// qupls_mc_sequencer: micro-code sequencer; passes mip==0 instructions through, otherwise walks the micro-code ROM issuing one micro-op per word (ports: clk/rst, flush_i, ins_* upstream handshake, rom_* ROM read, uop_* downstream handshake, busy_o)
module qupls_mc_sequencer #(
  parameter int INS_W = 48,
  parameter int MCA_W = 12,
  parameter int CNT_W = 4,
  localparam int UOP_W = INS_W + MCA_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             ins_valid_i,
  output logic             ins_ready_o,
  input  logic [INS_W-1:0] ins_i,
  input  logic [MCA_W-1:0] mip_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             rom_en_o,
  output logic [MCA_W-1:0] rom_addr_o,
  input  logic [UOP_W-1:0] rom_data_i,
  output logic             uop_valid_o,
  input  logic             uop_ready_i,
  output logic [INS_W-1:0] uop_o,
  output logic             uop_mc_o,
  output logic             uop_last_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, PASS, FETCH, ISSUE} state_t;
  state_t state_q, state_d;
  logic [MCA_W-1:0] upc_q, upc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [INS_W-1:0] pass_q, pass_d;
  logic accept, pass_in, w_last, w_loop;
  logic [MCA_W-1:0] w_tgt;
  assign w_last = rom_data_i[UOP_W-1];
  assign w_loop = rom_data_i[UOP_W-2];
  assign w_tgt = rom_data_i[UOP_W-3 -: MCA_W];
  assign pass_in = mip_i == '0;
  assign ins_ready_o = ~rst & ~flush_i & ((state_q == IDLE) | (state_q == PASS & uop_ready_i));
  assign accept = ins_valid_i & ins_ready_o;
  assign rom_en_o = state_q == FETCH;
  assign rom_addr_o = upc_q;
  assign uop_valid_o = (state_q == PASS) | (state_q == ISSUE);
  assign uop_mc_o = state_q == ISSUE;
  assign uop_last_o = (state_q == PASS) | (state_q == ISSUE & w_last);
  assign uop_o = state_q == ISSUE ? rom_data_i[INS_W-1:0] : (state_q == PASS ? pass_q : '0);
  assign busy_o = (state_q == FETCH) | (state_q == ISSUE);
  always_comb begin
    state_d = state_q;
    upc_d = upc_q;
    cnt_d = cnt_q;
    pass_d = pass_q;
    if (flush_i) begin
      state_d = IDLE;
      upc_d = '0;
      cnt_d = '0;
      pass_d = '0;
    end else if (accept) begin
      state_d = pass_in ? PASS : FETCH;
      pass_d = pass_in ? ins_i : pass_q;
      upc_d = pass_in ? upc_q : mip_i;
      cnt_d = pass_in ? cnt_q : cnt_i;
    end else if (state_q == PASS && uop_ready_i) begin
      state_d = IDLE;
    end else if (state_q == FETCH) begin
      state_d = ISSUE;
    end else if (state_q == ISSUE && uop_ready_i && w_last) begin
      state_d = IDLE;
    end else if (state_q == ISSUE && uop_ready_i) begin
      // a loop word jumps back while the counter is non-zero, then falls through
      state_d = FETCH;
      upc_d = (w_loop && cnt_q != '0) ? w_tgt : upc_q + 1'b1;
      cnt_d = (w_loop && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      upc_q <= '0;
      cnt_q <= '0;
      pass_q <= '0;
    end else begin
      state_q <= state_d;
      upc_q <= upc_d;
      cnt_q <= cnt_d;
      pass_q <= pass_d;
    end
  end
endmodule
